// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register control outputs of the stall/flush controller.
// master = the controller, slave = the datapath that feeds hazards and consumes enables.
interface pipe_ctrl_if;
  logic [2:0]  id_rs;
  logic        id_rs_used;
  logic [2:0]  id_rt;
  logic        id_rt_used;
  logic        ex_mem_read;
  logic        ex_reg_w_en;
  logic [2:0]  ex_w_reg;
  logic        br_taken;
  logic        imem_stall;
  logic        dmem_req;
  logic        dmem_stall;
  logic        halt_mem;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  modport master (
    input  id_rs, id_rs_used, id_rt, id_rt_used, ex_mem_read, ex_reg_w_en, ex_w_reg,
           br_taken, imem_stall, dmem_req, dmem_stall, halt_mem,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, halted, state, stall_cnt
  );

  modport slave (
    output id_rs, id_rs_used, id_rt, id_rt_used, ex_mem_read, ex_reg_w_en, ex_w_reg,
           br_taken, imem_stall, dmem_req, dmem_stall, halt_mem,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, halted, state, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline: freeze, halt drain, branch, load-use, fetch stall.
// Optional stall-cycle counter enabled by defining PIPE_CTRL_STATS_EN.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic load_use, freeze;

  assign load_use = bus.ex_mem_read && bus.ex_reg_w_en &&
                    ((bus.id_rs_used && (bus.id_rs == bus.ex_w_reg)) ||
                     (bus.id_rt_used && (bus.id_rt == bus.ex_w_reg)));

  // A pending data access stalls everything, including branch and halt, which are re-seen later.
  assign freeze = bus.dmem_stall &&
                  (((state_q == RUN) && bus.dmem_req) || (state_q == MEM_WAIT));

  // NOTE: asynchronous reset is applied in the sensitivity list; state uses non-blocking assignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every variable is given a default first so no path can infer a latch.
    state_d      = state_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      state_d = RUN;
    end else if (freeze) begin
      state_d = MEM_WAIT;
    end else begin
      unique case (state_q)
        DRAIN: begin
          mem_wb_en = 1'b1;
          state_d   = HALTED;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          // RUN, or MEM_WAIT whose access has just completed.
          state_d = RUN;
          if (bus.halt_mem) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_en    = 1'b1;
            state_d      = DRAIN;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (bus.br_taken) begin
              // The PC loads the target even while imem stalls; the two wrong-path slots become bubbles.
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end else if (bus.imem_stall) begin
              pc_en       = 1'b0;
              if_id_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.halted       = halted;
  assign bus.state        = state_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (!pc_en && (state_q != HALTED) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage 16-bit pipeline. It generates the write enables and bubble-insert (flush) strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects, multi-cycle data-memory stalls, instruction-memory stalls and halt draining. All pipeline registers in the core take their `en` from this block.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- id_rs  in  3  rs field of the instruction in ID
- id_rs_used  in  1  the instruction in ID reads rs
- id_rt  in  3  rt field of the instruction in ID
- id_rt_used  in  1  the instruction in ID reads rt
- ex_mem_read  in  1  the instruction in EX is a load
- ex_reg_w_en  in  1  the instruction in EX writes the register file
- ex_w_reg  in  3  destination register of the instruction in EX
- br_taken  in  1  EX resolved a taken branch or jump (the PC loads the target)
- imem_stall  in  1  instruction memory is not returning a valid word this cycle
- dmem_req  in  1  the instruction in MEM is a load or store
- dmem_stall  in  1  data memory is busy; the MEM access is not complete
- halt_mem  in  1  a HALT instruction is in MEM
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register write enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  the register loads a NOP/bubble on the next edge; takes precedence over the register's `en`
- halted  out  1  the core is halted
- state  out  2  FSM state (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3)
- stall_cnt  out  16  stall-cycle counter (see Configuration)

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and inputs. Evaluate the cases below in priority order; the first case that matches sets the outputs.
- **Freeze.** Applies when `dmem_stall` is high and either (`dmem_req` in RUN) or (state is MEM_WAIT).
  - All `*_en` = 0 and all flushes = 0.
  - RUN moves to MEM_WAIT.
  - `br_taken` and `halt_mem` are ignored; they are held upstream and re-seen later.
- **MEM_WAIT with `dmem_stall`=0.** The access completes. Evaluate the cases below exactly as in RUN, and return to RUN.
- **Halt.** Applies when `halt_mem` is high in RUN.
  - `pc_en`=0; `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1 (younger instructions are squashed); `mem_wb_en`=1.
  - Next state is DRAIN.
- **DRAIN.** `mem_wb_en`=1 (the bubble follows HALT into WB); all other enables = 0; flushes = 0. Next state is HALTED.
- **HALTED.** All enables = 0, flushes = 0, `halted`=1. The block stays here until `rst`.
- **Branch.** Applies when `br_taken` is high.
  - `pc_en`=1 even if `imem_stall` is high (the fetch is abandoned).
  - `if_id_flush`=`id_ex_flush`=1.
  - `ex_mem_en`=`mem_wb_en`=1.
  - Branch overrides load-use, because the stalled instruction is wrong-path.
- **Load-use.** Applies when `ex_mem_read` && `ex_reg_w_en` && ((`id_rs_used` && `id_rs`==`ex_w_reg`) || (`id_rt_used` && `id_rt`==`ex_w_reg`)).
  - `pc_en`=`if_id_en`=0.
  - `id_ex_flush`=1.
  - `ex_mem_en`=`mem_wb_en`=1.
- **I-fetch stall.** Applies when `imem_stall` is high.
  - `pc_en`=0; `if_id_flush`=1.
  - `id_ex_en`=`ex_mem_en`=`mem_wb_en`=1.
- **Otherwise.** All enables = 1; flushes = 0.
- Register r0 is not special: a match on r0 still causes a load-use stall.

## Timing
- Zero-cycle latency: outputs respond combinationally to the inputs in the same cycle. Only `state` and `stall_cnt` are registered.
- While `rst` is high, and immediately after it deasserts:
  - state = RUN
  - all `*_en` = 0 while `rst` is high
  - flushes = 0, `halted` = 0, `stall_cnt` = 0
- A load-use hazard costs exactly 1 bubble. A taken branch costs 2 bubbles.
- From `halt_mem` to `halted`=1 takes exactly 2 edges, assuming no freeze.
- Reset mid-freeze or mid-drain returns the block to RUN immediately; no memory handshake is completed.

## Configuration
- `PIPE_CTRL_STATS_EN` defined:
  - `stall_cnt` increments on each rising edge where `pc_en`==0 and state!=HALTED. Cycles with `rst` high do not count.
  - The counter saturates at 16'hFFFF.
  - It is cleared only by `rst`.
- `PIPE_CTRL_STATS_EN` not defined: the `stall_cnt` port remains and is tied to 16'h0000; no counter flops are present.

## Test plan
- **Load-use.** `ex_mem_read`=1, `ex_reg_w_en`=1, `ex_w_reg`=3, `id_rs`=3, `id_rs_used`=1 for 1 cycle → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, `ex_mem_en`=1. Repeat with `id_rs_used`=0 → no stall.
- **Branch over load-use.** `br_taken`=1 together with the load-use condition → `pc_en`=1, `if_id_flush`=`id_ex_flush`=1, `if_id_en` unaffected.
- **D-mem stall.** `dmem_req`=1, `dmem_stall`=1 for 4 cycles with `br_taken`=1 → state = MEM_WAIT, all enables 0 for 4 cycles. On the 5th cycle `dmem_stall`=0 → branch outputs asserted, state = RUN. With stats enabled, `stall_cnt`=4.
- **I-fetch stall.** `imem_stall`=1 for 2 cycles → `pc_en`=0, `if_id_flush`=1, `mem_wb_en`=1 each cycle.
- **Halt.** Pulse `halt_mem` → next 2 states DRAIN then HALTED, `halted`=1. Further `br_taken`/`imem_stall` activity has no effect. Asserting `rst` returns state = 0 and `halted`=0.
- **Saturation (stats enabled).** Hold `imem_stall`=1 for 70000 cycles → `stall_cnt`=16'hFFFF and it holds that value.
